stream_comparator: RTL and testbench
====================================

STREAM_COMPARATOR -- requirements
Module: stream_comparator

Interface
REQ-001 The module SHALL have parameter N, default 8, giving the width of one compare lane in bits.
REQ-002 The module SHALL have parameter CH, default 4, giving the number of parallel lanes.
REQ-003 The module SHALL have parameter CNT_W, default 16, giving the width of the mismatch counter.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: the reset, asynchronous and active-high.
REQ-006 Port in_valid, input, 1: an input transaction is offered.
REQ-007 Port in_ready, output, 1: the block can accept an input transaction.
REQ-008 Port mode, input, 2: the compare mode (cmp_mode_t), sampled with the transaction.
REQ-009 Port x, input, CH*N: operand A; lane i occupies bits [i*N +: N].
REQ-010 Port y, input, CH*N: operand B; lane layout is identical to x.
REQ-011 Port clr, input, 1: synchronous clear of the counter and the sticky status.
REQ-012 Port out_valid, output, 1: the result register holds a valid result.
REQ-013 Port out_ready, input, 1: downstream accepts the result.
REQ-014 Port res, output, CH: per-lane compare result.
REQ-015 Port all_true, output, 1: AND of all bits of res.
REQ-016 Port mism_cnt, output, CNT_W: count of accepted transactions with all_true=0.
REQ-017 Port first_idx, output, max(1,$clog2(CH)): lowest failing lane of the first failing transaction.
REQ-018 Port first_vld, output, 1: first_idx is valid.

Function
REQ-019 Mode encodings SHALL be: 00 EQ (x==y), 01 NE (x!=y), 10 LT (unsigned x<y), 11 GT (unsigned x>y), evaluated per lane.
REQ-020 An input transfer SHALL occur when in_valid && in_ready are both high at a clock edge.
REQ-021 An output transfer SHALL occur when out_valid && out_ready are both high at a clock edge.
REQ-022 The output stage SHALL be a two-state FSM, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-023 EMPTY SHALL move to FULL on an input transfer.
REQ-024 FULL SHALL move to EMPTY on an output transfer without a simultaneous input transfer.
REQ-025 FULL SHALL remain FULL on a simultaneous input and output transfer, loading the new result.
REQ-026 in_ready SHALL equal !out_valid || out_ready, giving combinational back-pressure.
REQ-027 Latency SHALL be 1 cycle: the result of the transfer at edge k appears on res and all_true after edge k.
REQ-028 Throughput SHALL be 1 transaction per cycle when out_ready is held high.
REQ-029 res, all_true, and out_valid SHALL be held stable while out_valid=1 and out_ready=0.
REQ-030 mism_cnt SHALL increment by 1 on each input transfer whose result has all_true=0, and SHALL saturate at 2^CNT_W-1 without wrap-around.
REQ-031 On the first failing transfer while first_vld=0, first_idx SHALL load the lowest i with res[i]=0 and first_vld SHALL be set.
REQ-032 first_idx and first_vld SHALL be sticky until clr or rst.
REQ-033 clr SHALL zero mism_cnt, first_vld, and first_idx.
REQ-034 When clr coincides with a failing transfer, clr SHALL win: the transfer is not counted or captured, but its result is still presented on res.
REQ-035 clr SHALL NOT affect out_valid or the data path.

Reset
REQ-036 While rst=1, out_valid, res, all_true, mism_cnt, first_idx, and first_vld SHALL all be 0, and the FSM SHALL be EMPTY.
REQ-037 Assertion of rst mid-transaction SHALL discard any held result; in_ready SHALL read 1 after release.
REQ-038 The block SHALL accept a transfer on the first clock edge after rst deasserts.

Structure
REQ-039 Package cmp_pkg SHALL hold the cmp_mode_t enum (CMP_EQ, CMP_NE, CMP_LT, CMP_GT) and the default parameter constants.
REQ-040 Per-lane logic SHALL be a combinational sub-module cmp_lane (parameter N; inputs a, b, mode; output r), instantiated CH times by generate.
REQ-041 All sequential logic (FSM, result register, counter, sticky capture) SHALL reside in stream_comparator.

Verification (N=8, CH=4 unless stated)
REQ-042 Reset: rst=1 with random inputs -> out_valid=0, mism_cnt=0, first_vld=0, in_ready=1.
REQ-043 EQ: x=32'hA5A5_1234, y=32'hA5A5_1234 transferred -> next cycle out_valid=1, res=4'b1111, all_true=1, mism_cnt=0.
REQ-044 LT: x=32'h0180_FF00, y=32'h027F_FF01 -> res=4'b1001, all_true=0, mism_cnt=1, first_idx=1, first_vld=1.
REQ-045 Back-pressure: out_ready=0 for 3 cycles with a second transfer pending -> in_ready=0, res stable, mism_cnt unchanged; on out_ready=1 the second result appears the next cycle.
REQ-046 Saturation: CNT_W=4, 20 back-to-back failing NE transfers with x==y -> mism_cnt=15 and holds.
REQ-047 clr coinciding with a failing transfer -> mism_cnt=0, first_vld=0, res shows the failing result; rst pulse while FULL -> out_valid=0 immediately.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and default parameters for the stream comparator.
package cmp_pkg;

  // Per-lane compare operation, sampled with each input transaction.
  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_NE = 2'b01,
    CMP_LT = 2'b10,
    CMP_GT = 2'b11
  } cmp_mode_t;

  localparam int unsigned DEF_N     = 8;
  localparam int unsigned DEF_CH    = 4;
  localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/cmp_lane.sv
// One compare lane: purely combinational, unsigned compare of a against b.
module cmp_lane
  import cmp_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  cmp_mode_t    mode,
  output logic         r
);

  // Select the relation requested by the mode.
  always_comb begin
    r = 1'b0;
    case (mode)
      CMP_EQ:  r = (a == b);
      CMP_NE:  r = (a != b);
      CMP_LT:  r = (a < b);
      CMP_GT:  r = (a > b);
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/stream_comparator.sv
// Multi-lane stream comparator with a one-entry output register,
// a saturating mismatch counter and sticky first-failure capture.
module stream_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned CH    = DEF_CH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  localparam int unsigned IDX_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [CH*N-1:0]   x,
  input  logic [CH*N-1:0]   y,
  input  logic              clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH-1:0]     res,
  output logic              all_true,
  output logic [CNT_W-1:0]  mism_cnt,
  output logic [IDX_W-1:0]  first_idx,
  output logic              first_vld
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]       state_q, state_d;
  logic [CH-1:0]    res_q, res_d;
  logic             all_true_q, all_true_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic             fvld_q, fvld_d;

  cmp_mode_t        mode_e;
  logic [CH-1:0]    lane_res;
  logic [IDX_W-1:0] low_idx;
  logic             in_xfer, out_xfer, fail_xfer;

  assign mode_e = cmp_mode_t'(mode);

  for (genvar i = 0; i < CH; i++) begin : g_lane
    cmp_lane #(
      .N(N)
    ) u_lane (
      .a    (x[i*N +: N]),
      .b    (y[i*N +: N]),
      .mode (mode_e),
      .r    (lane_res[i])
    );
  end

  assign out_valid = (state_q == ST_FULL);
  // Register can take a new result if empty or being drained this cycle.
  assign in_ready  = !out_valid || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign fail_xfer = in_xfer && !(&lane_res);

  assign res       = res_q;
  assign all_true  = all_true_q;
  assign mism_cnt  = cnt_q;
  assign first_idx = fidx_q;
  assign first_vld = fvld_q;

  // Lowest lane whose compare failed (descending scan so the lowest wins).
  always_comb begin
    low_idx = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (!lane_res[i]) low_idx = IDX_W'(i);
    end
  end

  // Output-stage FSM: EMPTY/FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_xfer) state_d = ST_FULL;
      ST_FULL:  if (out_xfer && !in_xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Result register loads on every accepted transaction, otherwise holds.
  always_comb begin
    res_d      = res_q;
    all_true_d = all_true_q;
    if (in_xfer) begin
      res_d      = lane_res;
      all_true_d = &lane_res;
    end
  end

  // Mismatch statistics; clr takes priority over a coincident failure.
  always_comb begin
    cnt_d  = cnt_q;
    fidx_d = fidx_q;
    fvld_d = fvld_q;
    if (clr) begin
      cnt_d  = '0;
      fidx_d = '0;
      fvld_d = 1'b0;
    end else if (fail_xfer) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (!fvld_q) begin
        fidx_d = low_idx;
        fvld_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      res_q      <= '0;
      all_true_q <= 1'b0;
      cnt_q      <= '0;
      fidx_q     <= '0;
      fvld_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      all_true_q <= all_true_d;
      cnt_q      <= cnt_d;
      fidx_q     <= fidx_d;
      fvld_q     <= fvld_d;
    end
  end

endmodule

// File: tb/tb_stream_comparator.sv
// Self-checking bench for stream_comparator (N=8, CH=4), with a second
// instance at CNT_W=4 to exercise counter saturation.
module tb_stream_comparator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_s;
  logic [1:0]  mode = 2'd0;
  logic [31:0] x = '0, y = '0;
  logic        clr = 1'b0;
  logic        out_valid, out_valid_s;
  logic        out_ready = 1'b1;
  logic [3:0]  res, res_s;
  logic        all_true, all_true_s;
  logic [15:0] mism_cnt;
  logic [3:0]  mism_cnt_s;
  logic [1:0]  first_idx, first_idx_s;
  logic        first_vld, first_vld_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_comparator #(.N(8), .CH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x(x), .y(y), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .all_true(all_true), .mism_cnt(mism_cnt), .first_idx(first_idx),
    .first_vld(first_vld)
  );

  stream_comparator #(.N(8), .CH(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .mode(mode),
    .x(x), .y(y), .clr(clr), .out_valid(out_valid_s), .out_ready(out_ready),
    .res(res_s), .all_true(all_true_s), .mism_cnt(mism_cnt_s), .first_idx(first_idx_s),
    .first_vld(first_vld_s)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  res;
    logic        all;
    int          cnt;
    logic [1:0]  fidx;
    logic        fvld;
  } vec_t;

  vec_t tbl[6];

  // Reference model state.
  logic       m_valid;
  logic [3:0] m_res;
  logic       m_all;
  int         m_cnt;
  int         m_fidx;
  logic       m_fvld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec-level lane relation computed from the integer lane values.
  function automatic logic [3:0] ref_res(input logic [1:0] md, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      int av, bv;
      av = int'((a >> (8 * i)) & 32'hFF);
      bv = int'((b >> (8 * i)) & 32'hFF);
      case (md)
        2'd0: r[i] = (av == bv);
        2'd1: r[i] = (av != bv);
        2'd2: r[i] = (av < bv);
        default: r[i] = (av > bv);
      endcase
    end
    return r;
  endfunction

  function automatic int lowest_zero(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (!r[i]) return i;
    return 0;
  endfunction

  initial begin
    tbl[0] = '{2'd0, 32'hA5A5_1234, 32'hA5A5_1234, 4'b1111, 1'b1, 0, 2'd0, 1'b0};
    tbl[1] = '{2'd2, 32'h0180_FF00, 32'h027F_FF01, 4'b1001, 1'b0, 1, 2'd1, 1'b1};
    tbl[2] = '{2'd1, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b0, 2, 2'd1, 1'b1};
    tbl[3] = '{2'd3, 32'h8000_FF10, 32'h7F01_FE10, 4'b1010, 1'b0, 3, 2'd1, 1'b1};
    tbl[4] = '{2'd1, 32'h1234_5678, 32'h1234_5679, 4'b0001, 1'b0, 4, 2'd1, 1'b1};
    tbl[5] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111, 1'b1, 4, 2'd1, 1'b1};

    // Reset with random inputs applied.
    in_valid = 1'b1; mode = 2'($urandom); x = $urandom; y = $urandom; clr = 1'b0;
    out_ready = 1'($urandom);
    step(); step();
    check("rst out_valid", 32'(out_valid), 0);
    check("rst res", 32'(res), 0);
    check("rst all_true", 32'(all_true), 0);
    check("rst mism_cnt", 32'(mism_cnt), 0);
    check("rst first_vld", 32'(first_vld), 0);
    check("rst first_idx", 32'(first_idx), 0);
    check("rst in_ready", 32'(in_ready), 1);
    rst = 1'b0;

    // Table: back-to-back transfers with out_ready high, first one on the
    // very first edge after reset release.
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; mode = tbl[k].mode; x = tbl[k].x; y = tbl[k].y;
      #1;
      check($sformatf("tbl%0d in_ready", k), 32'(in_ready), 1);
      step();
      check($sformatf("tbl%0d out_valid", k), 32'(out_valid), 1);
      check($sformatf("tbl%0d res", k), 32'(res), 32'(tbl[k].res));
      check($sformatf("tbl%0d all_true", k), 32'(all_true), 32'(tbl[k].all));
      check($sformatf("tbl%0d mism_cnt", k), 32'(mism_cnt), tbl[k].cnt);
      check($sformatf("tbl%0d first_idx", k), 32'(first_idx), 32'(tbl[k].fidx));
      check($sformatf("tbl%0d first_vld", k), 32'(first_vld), 32'(tbl[k].fvld));
    end

    // Drain, then back-pressure with a second transfer pending.
    in_valid = 1'b0;
    step();
    check("drain out_valid", 32'(out_valid), 0);
    in_valid = 1'b1; mode = 2'd2; x = 32'h0; y = 32'h0; out_ready = 1'b0;
    step();
    check("bp first res", 32'(res), 32'h0);
    check("bp first cnt", 32'(mism_cnt), 5);
    mode = 2'd3; x = 32'hFFFF_FFFF; y = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp in_ready", 32'(in_ready), 0);
      step();
      check("bp out_valid", 32'(out_valid), 1);
      check("bp res stable", 32'(res), 32'h0);
      check("bp all_true stable", 32'(all_true), 0);
      check("bp cnt stable", 32'(mism_cnt), 5);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready), 1);
    step();
    check("bp second res", 32'(res), 32'hF);
    check("bp second all_true", 32'(all_true), 1);
    check("bp second out_valid", 32'(out_valid), 1);
    check("bp second cnt", 32'(mism_cnt), 5);
    in_valid = 1'b0;
    step();
    check("bp drained", 32'(out_valid), 0);

    // clr coinciding with a failing transfer.
    in_valid = 1'b1; mode = 2'd1; x = 32'hDEAD_BEEF; y = 32'hDEAD_BEEF; clr = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("clr out_valid", 32'(out_valid), 1);
    check("clr res", 32'(res), 32'h0);
    check("clr all_true", 32'(all_true), 0);
    check("clr mism_cnt", 32'(mism_cnt), 0);
    check("clr first_vld", 32'(first_vld), 0);
    check("clr first_idx", 32'(first_idx), 0);

    // Reset pulse while FULL clears the output immediately.
    step();
    check("pre-rst out_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("rst-pulse out_valid", 32'(out_valid), 0);
    check("rst-pulse res", 32'(res), 0);
    step();
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 32'(in_ready), 1);

    // Saturation: 20 failing NE transfers with x == y.
    out_ready = 1'b1; in_valid = 1'b1; mode = 2'd1;
    for (int k = 1; k <= 20; k++) begin
      x = $urandom; y = x;
      step();
      check($sformatf("sat cnt_s after %0d", k), 32'(mism_cnt_s), (k > 15) ? 15 : k);
    end
    in_valid = 1'b0;
    step();
    check("sat hold cnt_s", 32'(mism_cnt_s), 15);
    check("sat wide cnt", 32'(mism_cnt), 20);
    check("sat first_idx_s", 32'(first_idx_s), 0);

    // Random traffic against the reference model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_valid = 1'b0; m_res = '0; m_all = 1'b0; m_cnt = 0; m_fidx = 0; m_fvld = 1'b0;
    for (int k = 0; k < 400; k++) begin
      logic       m_rdy;
      logic [3:0] r;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      clr       = ($urandom_range(15) == 0);
      mode      = 2'($urandom);
      x         = $urandom;
      y         = $urandom;
      for (int i = 0; i < 4; i++) if ($urandom_range(1) == 0) y[8*i +: 8] = x[8*i +: 8];
      #1;
      m_rdy = !m_valid || out_ready;
      check("rnd in_ready", 32'(in_ready), 32'(m_rdy));
      r = ref_res(mode, x, y);
      if (clr) begin
        m_cnt = 0; m_fvld = 1'b0; m_fidx = 0;
      end else if (in_valid && m_rdy && r != 4'hF) begin
        if (m_cnt < 65535) m_cnt++;
        if (!m_fvld) begin
          m_fvld = 1'b1; m_fidx = lowest_zero(r);
        end
      end
      if (in_valid && m_rdy) begin
        m_valid = 1'b1; m_res = r; m_all = (r == 4'hF);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      step();
      check("rnd out_valid", 32'(out_valid), 32'(m_valid));
      check("rnd res", 32'(res), 32'(m_res));
      check("rnd all_true", 32'(all_true), 32'(m_all));
      check("rnd mism_cnt", 32'(mism_cnt), m_cnt);
      check("rnd first_vld", 32'(first_vld), 32'(m_fvld));
      check("rnd first_idx", 32'(first_idx), m_fidx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
